// File: rtl/ahb_mgr_arbiter.sv
// Two-manager AHB-Lite bus arbiter: round-robin address-phase ownership with a
// one-IDLE-cycle handover and data-phase routing back to the issuing manager.
module ahb_mgr_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_hclk,
  input  logic                  i_hreset,
  input  logic [1:0]            i_htrans_m0,
  input  logic [ADDR_WIDTH-1:0] i_haddr_m0,
  input  logic                  i_hwrite_m0,
  input  logic [2:0]            i_hsize_m0,
  input  logic [2:0]            i_hburst_m0,
  input  logic [DATA_WIDTH-1:0] i_hwdata_m0,
  output logic                  o_hready_m0,
  output logic                  o_hresp_m0,
  output logic [DATA_WIDTH-1:0] o_hrdata_m0,
  input  logic [1:0]            i_htrans_m1,
  input  logic [ADDR_WIDTH-1:0] i_haddr_m1,
  input  logic                  i_hwrite_m1,
  input  logic [2:0]            i_hsize_m1,
  input  logic [2:0]            i_hburst_m1,
  input  logic [DATA_WIDTH-1:0] i_hwdata_m1,
  output logic                  o_hready_m1,
  output logic                  o_hresp_m1,
  output logic [DATA_WIDTH-1:0] o_hrdata_m1,
  output logic [ADDR_WIDTH-1:0] o_haddr,
  output logic [1:0]            o_htrans,
  output logic                  o_hwrite,
  output logic [2:0]            o_hsize,
  output logic [2:0]            o_hburst,
  output logic [DATA_WIDTH-1:0] o_hwdata,
  input  logic                  i_hready,
  input  logic                  i_hresp,
  input  logic [DATA_WIDTH-1:0] i_hrdata,
  output logic [1:0]            o_grant
);

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_BUSY   = 2'b01;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ    = 2'b11;

  typedef enum logic {OWN0 = 1'b0, OWN1 = 1'b1} state_t;

  state_t     state, state_nxt;
  logic       downer, downer_nxt;
  logic       dvalid, dvalid_nxt;
  logic       last, last_nxt;
  logic       own;
  logic [1:0] own_trans, oth_trans;
  logic       locked, oth_req, own_req, own_idle, sw;

  assign own       = (state == OWN1);
  assign own_trans = own ? i_htrans_m1 : i_htrans_m0;
  assign oth_trans = own ? i_htrans_m0 : i_htrans_m1;
  assign locked    = (own_trans == HT_SEQ) || (own_trans == HT_BUSY);
  assign oth_req   = (oth_trans == HT_NONSEQ);
  assign own_req   = (own_trans == HT_NONSEQ);
  assign own_idle  = (own_trans == HT_IDLE);
  assign sw        = i_hready && !locked && oth_req && (own_idle || (own_req && (last == own)));

  always_ff @(posedge i_hclk or negedge i_hreset) begin
    if (!i_hreset) begin
      state  <= OWN0;
      downer <= 1'b0;
      dvalid <= 1'b0;
      last   <= 1'b0;
    end else begin
      state  <= state_nxt;
      downer <= downer_nxt;
      dvalid <= dvalid_nxt;
      last   <= last_nxt;
    end
  end

  // last records whose NONSEQ was most recently accepted, so a freshly granted
  // manager always gets one transfer before it can be switched away again.
  always_comb begin
    state_nxt  = state;
    downer_nxt = downer;
    dvalid_nxt = dvalid;
    last_nxt   = last;
    if (i_hready) begin
      dvalid_nxt = (o_htrans == HT_NONSEQ) || (o_htrans == HT_SEQ);
      downer_nxt = own;
      if (sw)
        state_nxt = own ? OWN0 : OWN1;
      else if (o_htrans == HT_NONSEQ)
        last_nxt = own;
    end
  end

  always_comb begin
    o_htrans = (!i_hreset || sw) ? HT_IDLE : own_trans;
    o_haddr  = own ? i_haddr_m1  : i_haddr_m0;
    o_hwrite = own ? i_hwrite_m1 : i_hwrite_m0;
    o_hsize  = own ? i_hsize_m1  : i_hsize_m0;
    o_hburst = own ? i_hburst_m1 : i_hburst_m0;
    o_hwdata = (dvalid && downer) ? i_hwdata_m1 : i_hwdata_m0;
    o_grant  = own ? 2'b10 : 2'b01;
  end

  assign o_hrdata_m0 = i_hrdata;
  assign o_hrdata_m1 = i_hrdata;
  assign o_hresp_m0  = dvalid && !downer && i_hresp;
  assign o_hresp_m1  = dvalid && downer && i_hresp;

  // A waiting non-owner is stalled so its NONSEQ stays on its own bus until granted.
  always_comb begin
    if (!own && sw)
      o_hready_m0 = 1'b0;
    else if (!own || (dvalid && !downer))
      o_hready_m0 = i_hready;
    else if (i_htrans_m0 == HT_NONSEQ)
      o_hready_m0 = 1'b0;
    else
      o_hready_m0 = 1'b1;

    if (own && sw)
      o_hready_m1 = 1'b0;
    else if (own || (dvalid && downer))
      o_hready_m1 = i_hready;
    else if (i_htrans_m1 == HT_NONSEQ)
      o_hready_m1 = 1'b0;
    else
      o_hready_m1 = 1'b1;
  end

endmodule
